// File: rtl/tracker_pkg.sv
// Shared definitions for the beacon/GPS tracker link: symbol codes,
// mode encodings and the transmitter state enum.
package tracker_pkg;

    // Symbol codes on the 2-bit tracker link (shared with the receiver).
    localparam logic [1:0] SYM_BCN  = 2'b00;
    localparam logic [1:0] SYM_TOG  = 2'b01;
    localparam logic [1:0] SYM_GPS  = 2'b11;
    localparam logic [1:0] SYM_RSVD = 2'b10;

    // Mode encodings used on mode_req / cur_mode.
    localparam logic MODE_BCN = 1'b0;
    localparam logic MODE_GPS = 1'b1;

    // Counter widths: toggle hold covers 0..14, dwell covers 0..255.
    localparam int HOLD_W  = 4;
    localparam int DWELL_W = 8;

    // Transmitter states.
    typedef enum logic [1:0] {
        BCN    = 2'b00,
        TOG_UP = 2'b01,
        GPS    = 2'b10,
        TOG_DN = 2'b11
    } state_t;

    // Steady symbol for a mode value.
    function automatic logic [1:0] steady_sym(input logic mode);
        return (mode == MODE_GPS) ? SYM_GPS : SYM_BCN;
    endfunction

endpackage

// File: rtl/tracker_hold_counter.sv
// Loadable down-counter with a zero flag. Load wins over decrement;
// decrement saturates at zero so the flag stays up once reached.
module tracker_hold_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count;

    // Count register: load, else saturating decrement.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/tracker_symbol_tx.sv
// Mode-switch transmitter for the tracker link. Requests arrive over a
// valid/ready handshake; a switch emits the toggle symbol for TOGGLE_LEN
// cycles, then the new steady symbol, then holds off new requests for
// MIN_DWELL cycles.
module tracker_symbol_tx
    import tracker_pkg::*;
#(
    parameter int TOGGLE_LEN = 2,
    parameter int MIN_DWELL  = 4,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode_req_valid,
    input  logic             mode_req,
    output logic             mode_req_ready,
    output logic [1:0]       sym,
    output logic             cur_mode,
    output logic             busy,
    output logic [CNT_W-1:0] switch_count
);

    // Reject illegal configurations while elaborating.
    if (TOGGLE_LEN < 1 || TOGGLE_LEN > 15) begin : g_bad_toggle
        $fatal(1, "tracker_symbol_tx: TOGGLE_LEN must be 1..15");
    end
    if (CNT_W < 1) begin : g_bad_cnt
        $fatal(1, "tracker_symbol_tx: CNT_W must be >= 1");
    end
    if (MIN_DWELL < 0 || MIN_DWELL > 255) begin : g_bad_dwell
        $fatal(1, "tracker_symbol_tx: MIN_DWELL must be 0..255");
    end

    localparam logic [HOLD_W-1:0]  HOLD_LOAD  = HOLD_W'(TOGGLE_LEN - 1);
    localparam logic [DWELL_W-1:0] DWELL_LOAD = DWELL_W'(MIN_DWELL);

    state_t state;
    logic   in_tog;
    logic   hold_zero;
    logic   dwell_zero;
    logic   accept;
    logic   start_sw;
    logic   tog_done;

    assign in_tog = (state == TOG_UP) || (state == TOG_DN);

    // Ready depends only on registers (and rst), never on valid.
    assign mode_req_ready = !in_tog && dwell_zero && !rst;
    assign accept         = mode_req_valid && mode_req_ready;

    // A request for the mode already being signalled is taken but does nothing.
    assign start_sw = accept && (mode_req != cur_mode);
    assign tog_done = in_tog && hold_zero;

    assign busy = in_tog || !dwell_zero;

    // Toggle hold: loaded on a switch, counts down while the toggle is sent.
    tracker_hold_counter #(.W(HOLD_W)) u_hold (
        .clk      (clk),
        .rst      (rst),
        .load     (start_sw),
        .load_val (HOLD_LOAD),
        .dec      (in_tog),
        .zero     (hold_zero)
    );

    // Dwell: loaded as the steady symbol starts, counts down in steady states.
    tracker_hold_counter #(.W(DWELL_W)) u_dwell (
        .clk      (clk),
        .rst      (rst),
        .load     (tog_done),
        .load_val (DWELL_LOAD),
        .dec      (!in_tog),
        .zero     (dwell_zero)
    );

    // Mode FSM; sym, cur_mode and switch_count follow the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= BCN;
            sym          <= SYM_BCN;
            cur_mode     <= MODE_BCN;
            switch_count <= '0;
        end else begin
            case (state)
                BCN: begin
                    if (start_sw) begin
                        state <= TOG_UP;
                        sym   <= SYM_TOG;
                    end
                end
                TOG_UP: begin
                    if (hold_zero) begin
                        state        <= GPS;
                        sym          <= steady_sym(MODE_GPS);
                        cur_mode     <= MODE_GPS;
                        switch_count <= switch_count + CNT_W'(1);
                    end
                end
                GPS: begin
                    if (start_sw) begin
                        state <= TOG_DN;
                        sym   <= SYM_TOG;
                    end
                end
                TOG_DN: begin
                    if (hold_zero) begin
                        state        <= BCN;
                        sym          <= steady_sym(MODE_BCN);
                        cur_mode     <= MODE_BCN;
                        switch_count <= switch_count + CNT_W'(1);
                    end
                end
                default: begin
                    state    <= BCN;
                    sym      <= SYM_BCN;
                    cur_mode <= MODE_BCN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tracker_symbol_tx.sv
// Bench for tracker_symbol_tx: two configurations driven side by side and
// compared every cycle against a timeline model (cycles since accept).
module tb_tracker_symbol_tx;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       v0 = 1'b0, r0 = 1'b0, v1 = 1'b0, r1 = 1'b0;
    logic       rdy0, cm0, busy0, rdy1, cm1, busy1;
    logic [1:0] sym0, sym1;
    logic [7:0] sc0;
    logic [1:0] sc1;

    tracker_symbol_tx #(.TOGGLE_LEN(2), .MIN_DWELL(4), .CNT_W(8)) dut0 (
        .clk(clk), .rst(rst), .mode_req_valid(v0), .mode_req(r0),
        .mode_req_ready(rdy0), .sym(sym0), .cur_mode(cm0), .busy(busy0),
        .switch_count(sc0));

    tracker_symbol_tx #(.TOGGLE_LEN(3), .MIN_DWELL(0), .CNT_W(2)) dut1 (
        .clk(clk), .rst(rst), .mode_req_valid(v1), .mode_req(r1),
        .mode_req_ready(rdy1), .sym(sym1), .cur_mode(cm1), .busy(busy1),
        .switch_count(sc1));

    int total = 0;
    int bad   = 0;

    // Model: per instance, edges since the last switching accept.
    localparam int IDLE = 1000;
    int TL[2]    = '{2, 3};
    int MD[2]    = '{4, 0};
    int CMASK[2] = '{255, 3};
    int m_t[2];
    bit m_tgt[2];
    int m_cnt[2];
    bit acc[2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s at t=%0t observed=%0h expected=%0h", tag, $time, obs, exp);
        end
    endtask

    task automatic model_reset(input int i);
        m_t[i]   = IDLE;
        m_tgt[i] = 1'b0;
        m_cnt[i] = 0;
    endtask

    function automatic bit m_ready(input int i);
        return !rst && (m_t[i] >= TL[i] + MD[i]);
    endfunction

    function automatic logic [1:0] m_sym(input int i);
        if (m_t[i] < TL[i]) return 2'b01;
        return m_tgt[i] ? 2'b11 : 2'b00;
    endfunction

    function automatic logic m_mode(input int i);
        return (m_t[i] < TL[i]) ? !m_tgt[i] : m_tgt[i];
    endfunction

    task automatic model_edge(input int i, input logic val, input logic req);
        bit rdy;
        acc[i] = 1'b0;
        if (rst) begin
            model_reset(i);
        end else begin
            rdy = m_ready(i);
            if (val && rdy) begin
                acc[i] = 1'b1;
                if (req != m_tgt[i]) begin
                    m_tgt[i] = req;
                    m_t[i]   = 0;
                end
            end else if (m_t[i] < IDLE) begin
                m_t[i]++;
                if (m_t[i] == TL[i]) m_cnt[i]++;
            end
        end
    endtask

    task automatic check_all();
        logic [1:0]  s;
        logic        cm, rd, bz;
        logic [31:0] sc;
        for (int i = 0; i < 2; i++) begin
            if (i == 0) begin
                s = sym0; cm = cm0; rd = rdy0; bz = busy0; sc = {24'b0, sc0};
            end else begin
                s = sym1; cm = cm1; rd = rdy1; bz = busy1; sc = {30'b0, sc1};
            end
            chk($sformatf("sym%0d", i), {30'b0, s}, {30'b0, m_sym(i)});
            chk($sformatf("rsvd%0d", i), {31'b0, (s === 2'b10)}, 32'd0);
            chk($sformatf("cur_mode%0d", i), {31'b0, cm}, {31'b0, m_mode(i)});
            chk($sformatf("ready%0d", i), {31'b0, rd}, {31'b0, m_ready(i)});
            chk($sformatf("busy%0d", i), {31'b0, bz},
                {31'b0, (!rst && (m_t[i] < TL[i] + MD[i]))});
            chk($sformatf("count%0d", i), sc, 32'(m_cnt[i] & CMASK[i]));
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge(0, v0, r0);
        model_edge(1, v1, r1);
        #1;
        check_all();
    endtask

    // Present a request and hold it until taken (bounded).
    task automatic run_req(input int i, input logic mode);
        bit got;
        got = 1'b0;
        if (i == 0) begin v0 = 1'b1; r0 = mode; end
        else        begin v1 = 1'b1; r1 = mode; end
        for (int n = 0; n < 100 && !got; n++) begin
            step();
            got = acc[i];
        end
        if (i == 0) v0 = 1'b0; else v1 = 1'b0;
        if (!got) chk($sformatf("accept_timeout%0d", i), 32'd0, 32'd1);
    endtask

    logic [1:0] exp_seq [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    initial begin
        model_reset(0);
        model_reset(1);

        // Reset state, then idle.
        #12;
        check_all();
        rst = 1'b0;
        #1;
        chk("ready_after_rst", {31'b0, rdy0}, 32'd1);
        for (int n = 0; n < 10; n++) step();

        // Switch to GPS: toggle two cycles, steady 11, dwell four.
        run_req(0, 1'b1);
        chk("t2_sym_k", {30'b0, sym0}, 32'h1);
        step();
        chk("t2_sym_k1", {30'b0, sym0}, 32'h1);
        step();
        chk("t2_sym_k2", {30'b0, sym0}, 32'h3);
        chk("t2_mode_k2", {31'b0, cm0}, 32'd1);
        for (int n = 0; n < 4; n++) step();
        chk("t2_ready_k6", {31'b0, rdy0}, 32'd1);
        chk("t2_busy_k6", {31'b0, busy0}, 32'd0);
        for (int n = 0; n < 3; n++) step();

        // Same-mode request in GPS is a no-op.
        run_req(0, 1'b1);
        chk("t4_sym", {30'b0, sym0}, 32'h3);
        chk("t4_count", {24'b0, sc0}, 32'd1);
        chk("t4_ready", {31'b0, rdy0}, 32'd1);
        step();

        // Back to beacon, then GPS and a held beacon request through the dwell.
        run_req(0, 1'b0);
        for (int n = 0; n < 8; n++) step();
        run_req(0, 1'b1);
        run_req(0, 1'b0);
        for (int n = 0; n < 8; n++) step();
        chk("t3_sym", {30'b0, sym0}, 32'h0);

        // Asynchronous reset in the middle of a toggle.
        v1 = 1'b1; r1 = 1'b1;
        run_req(0, 1'b1);
        v1 = 1'b0;
        #2;
        rst = 1'b1;
        model_reset(0);
        model_reset(1);
        #1;
        chk("t5_sym_async", {30'b0, sym0}, 32'h0);
        chk("t5_mode_async", {31'b0, cm0}, 32'd0);
        chk("t5_ready_async", {31'b0, rdy0}, 32'd0);
        check_all();
        step();
        step();
        #2;
        rst = 1'b0;
        step();
        chk("t5_count", {24'b0, sc0}, 32'd0);

        // Narrow counter wraps; zero dwell gives ready on the first steady cycle.
        for (int j = 0; j < 5; j++) begin
            run_req(1, !m_tgt[1]);
            for (int n = 0; n < 3; n++) step();
            chk($sformatf("t6_count_%0d", j), {30'b0, sc1}, {30'b0, exp_seq[j]});
            chk($sformatf("t6_ready_%0d", j), {31'b0, rdy1}, 32'd1);
        end

        // Random requesters on both instances.
        for (int n = 0; n < 600; n++) begin
            if (!v0 || acc[0]) begin
                v0 = ($urandom_range(0, 2) != 0);
                r0 = ($urandom_range(0, 3) != 0) ? !m_tgt[0] : m_tgt[0];
            end
            if (!v1 || acc[1]) begin
                v1 = ($urandom_range(0, 2) != 0);
                r1 = ($urandom_range(0, 3) != 0) ? !m_tgt[1] : m_tgt[1];
            end
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/tracker_symbol_tx.md
Name: tracker_symbol_tx

Overview:
Transmit-side companion to the team's beacon/GPS tracker FSM. Converts mode-switch requests, taken over a valid/ready handshake, into the 2-bit symbol stream the tracker consumes.
- Beacon mode sends steady 00; GPS mode sends steady 11.
- A switch sends a toggle symbol 01 held for a fixed count, then the new steady symbol, then a minimum dwell before the next request is accepted.
- Sits between the mode-control logic and the tracker's 2-bit input.

Parameters:
- TOGGLE_LEN, 2: cycles the 01 toggle symbol is held per switch; legal range 1..15.
- MIN_DWELL, 4: steady-symbol cycles required after a switch before mode_req_ready may rise; legal range 0..255.
- CNT_W, 8: width of switch_count; wraps modulo 2^CNT_W.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- mode_req_valid  in  1  request present.
- mode_req  in  1  requested mode: 0 = beacon, 1 = GPS; sampled only on accept.
- mode_req_ready  out  1  block can accept a request this cycle.
- sym  out  2  registered symbol to the tracker.
- cur_mode  out  1  mode currently being signalled: 0 = beacon, 1 = GPS.
- busy  out  1  high during a toggle or dwell.
- switch_count  out  CNT_W  number of completed mode switches, wrapping.

Behaviour:
- One clock domain: clk. rst is asynchronous and active-high. While rst is high: sym=00, cur_mode=0, busy=0, switch_count=0, mode_req_ready=0, state=BCN, hold counter=0, dwell counter=0.
- States:
  - BCN: sym=00.
  - TOG_UP: sym=01.
  - GPS: sym=11.
  - TOG_DN: sym=01.
- sym is a registered decode of the next state. Code 10 is reserved and is never driven.
- mode_req_ready = (state is BCN or GPS) and dwell counter == 0 and not rst. It is a combinational decode of registers only and never depends on mode_req_valid.
- Accept = mode_req_valid & mode_req_ready at a rising edge.
- Accept with mode_req equal to cur_mode: no-op. State and sym are unchanged, switch_count is not incremented, and ready stays high.
- Accept in BCN with mode_req=1 at edge k:
  - state goes to TOG_UP; hold counter loads TOGGLE_LEN-1.
  - sym=01 from edge k for exactly TOGGLE_LEN cycles.
  - When hold counter==0: state goes to GPS, sym=11, cur_mode=1, switch_count+1, dwell counter loads MIN_DWELL.
- Accept in GPS with mode_req=0 is symmetric: TOG_DN, then BCN, sym=00, cur_mode=0.
- cur_mode changes on the same edge sym leaves 01.
- In BCN/GPS the dwell counter decrements to 0 and saturates there. Ready rises when it reaches 0, exactly MIN_DWELL cycles after the steady symbol first appears. With MIN_DWELL=0, ready is high in the first steady cycle.
- busy = (state is TOG_UP or TOG_DN) or dwell counter != 0.
- While in TOG_*, mode_req_valid is ignored: ready=0, and nothing is queued or dropped silently. The requester must hold valid until ready.
- switch_count increments only on completed switches and wraps from 2^CNT_W-1 to 0.
- Reset mid-toggle: immediate return to BCN and sym=00. The partial switch is not counted.
- Back-to-back requests are possible only after the dwell period; minimum accept-to-accept spacing is TOGGLE_LEN+MIN_DWELL cycles.
- Parameter checks are elaboration-time: TOGGLE_LEN>=1 and CNT_W>=1; violations are a fatal error.

Decomposition:
- Shared package tracker_pkg holds:
  - SYM_BCN=2'b00, SYM_TOG=2'b01, SYM_GPS=2'b11, SYM_RSVD=2'b10 (these constants are shared with the tracker receiver).
  - State enum {BCN, TOG_UP, GPS, TOG_DN}.
  - MODE_BCN=0, MODE_GPS=1.
- One sub-module is natural: tracker_hold_counter, a loadable down-counter with a zero flag. It is instantiated twice, once for the toggle hold and once for the dwell.

Test Plan:
1. Reset, then idle with valid=0 for 10 cycles -> sym=00, cur_mode=0, ready=1 from the first cycle after rst falls, switch_count=0.
2. TOGGLE_LEN=2, MIN_DWELL=4; request GPS accepted at edge k -> sym=01 at edges k and k+1, sym=11 from k+2, cur_mode=1 at k+2, switch_count=1, ready=0 until k+6 and 1 from k+6, busy deasserts at k+6.
3. Request GPS then hold valid with mode_req=0 through the toggle/dwell -> no accept until ready; then sym=01 for 2 cycles, then 00; switch_count=2; never sym=10.
4. In GPS with ready=1, request GPS (same mode) -> accepted, sym stays 11, switch_count unchanged, ready stays 1.
5. Assert rst asynchronously mid-TOG_UP (between clock edges) -> sym=00, cur_mode=0, ready=0 immediately; after release the block is in BCN and switch_count=0.
6. CNT_W=2; perform 5 alternating switches -> switch_count sequence 1,2,3,0,1; MIN_DWELL=0 run shows ready high on the first steady-symbol cycle.
